// File: rtl/regfile_dump_engine_if.sv
// Byte stream from the register dump engine to the debug/display path.
// Each beat carries a register index, its captured value and a stale flag.
interface regfile_dump_engine_if;
  logic       valid;
  logic       ready;
  logic [2:0] addr;
  logic [7:0] data;
  logic       stale;

  modport master (output valid, addr, data, stale, input ready);
  modport slave  (input valid, addr, data, stale, output ready);
endinterface

// File: rtl/regfile_dump_engine.sv
// Walks registers FIRST_REG..LAST_REG through one read port and streams
// {index, value} beats out, flagging values overwritten while being held.
module regfile_dump_engine #(
  parameter int unsigned FIRST_REG  = 1,
  parameter int unsigned LAST_REG   = 7,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    rf_rd_addr,
  input  logic [7:0]                    rf_rd_data,
  input  logic                          rf_wr_en,
  input  logic [2:0]                    rf_wr_addr,
  regfile_dump_engine_if.master         out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] FIRST_IDX = 3'(FIRST_REG);
  localparam logic [2:0] LAST_IDX  = 3'(LAST_REG);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  if (LAST_REG < FIRST_REG || LAST_REG > 7 || GAP_CYCLES > 255) begin : g_bad_params
    $error("regfile_dump_engine: illegal FIRST_REG/LAST_REG/GAP_CYCLES");
  end

  logic [2:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] rd_addr_q, rd_addr_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] gap_q, gap_d;
  logic       stale_q, stale_d;
  logic       hs, wr_hit_idx, wr_hit_addr;

  assign hs          = (state_q == S_SEND) && out.ready;
  // Register 0 is hardwired, so writes to it can never make a byte stale.
  assign wr_hit_idx  = rf_wr_en && (rf_wr_addr == idx_q) && (idx_q != 3'd0);
  assign wr_hit_addr = rf_wr_en && (rf_wr_addr == addr_q) && (addr_q != 3'd0);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    gap_d     = gap_q;
    stale_d   = stale_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = FIRST_IDX;
        end
      end
      S_READ: begin
        rd_addr_d = idx_q;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Read data is the pre-write value, so a same-cycle write marks it stale.
          data_d  = rf_rd_data;
          addr_d  = idx_q;
          stale_d = wr_hit_idx;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (wr_hit_addr) stale_d = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            gap_d   = 8'd0;
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_READ;
          end
        end
      end
      S_GAP: begin
        if (abort)                  state_d = S_IDLE;
        else if (gap_q == GAP_LAST) state_d = S_READ;
        else                        gap_d   = gap_q + 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      rd_addr_q <= 3'd0;
      addr_q    <= 3'd0;
      data_q    <= 8'd0;
      gap_q     <= 8'd0;
      stale_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gap_q     <= gap_d;
      stale_q   <= stale_d;
    end
  end

  assign rf_rd_addr = (state_q == S_READ) ? idx_q : rd_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out.valid  = (state_q == S_SEND);
  assign out.addr   = addr_q;
  assign out.data   = data_q;
  assign out.stale  = stale_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Bench for regfile_dump_engine: default instance (R1..R7, no gap) and a
// FIRST_REG=0 / LAST_REG=2 / GAP_CYCLES=3 instance sharing one register file.
module tb_regfile_dump_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, abort_a, busy_a, done_a;
  logic [2:0] rd_addr_a;
  logic [7:0] rd_data_a;
  logic       start_b, abort_b, busy_b, done_b;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_b;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rf [8];

  regfile_dump_engine_if if_a ();
  regfile_dump_engine_if if_b ();

  regfile_dump_engine dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .rf_rd_addr(rd_addr_a), .rf_rd_data(rd_data_a),
    .rf_wr_en(wr_en), .rf_wr_addr(wr_addr), .out(if_a)
  );

  regfile_dump_engine #(.FIRST_REG(0), .LAST_REG(2), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .rf_rd_addr(rd_addr_b), .rf_rd_data(rd_data_b),
    .rf_wr_en(wr_en), .rf_wr_addr(wr_addr), .out(if_b)
  );

  // Register file: R0 reads zero, writes land at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (wr_en && wr_addr != 3'd0) begin
      rf[wr_addr] <= wr_data;
    end
  end
  assign rd_data_a = (rd_addr_a == 3'd0) ? 8'h00 : rf[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 3'd0) ? 8'h00 : rf[rd_addr_b];

  int hs_cnt_a = 0;
  always @(posedge clk) if (if_a.valid && if_a.ready) hs_cnt_a <= hs_cnt_a + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_default();
    for (int r = 1; r < 8; r++) write_reg(3'(r), 8'(17 * r));
  endtask

  task automatic start_a_pulse();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_byte(input logic [2:0] a);
    int i;
    for (i = 0; i < 60; i++) begin
      if (if_a.valid && if_a.addr == a) break;
      tick();
    end
    chk("wait_byte", int'(i < 60), 1);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60; i++) begin
      if (done_a) break;
      tick();
    end
    chk("wait_done", int'(i < 60), 1);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy_a, 0);
    chk({tag, "_done"},  done_a, 0);
    chk({tag, "_valid"}, if_a.valid, 0);
    chk({tag, "_stale"}, if_a.stale, 0);
    chk({tag, "_addr"},  if_a.addr, 0);
    chk({tag, "_data"},  if_a.data, 0);
    chk({tag, "_rdaddr"}, rd_addr_a, 0);
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic       valid;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] rd;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int base;
    // Basic dump, cycle n = 1..16 after the start edge; stray starts mid-dump.
    for (int n = 1; n <= 16; n++) begin
      tbl[n-1].start = (n == 5 || n == 9);
      tbl[n-1].ready = 1'b1;
      tbl[n-1].valid = (n % 2 == 0) && (n <= 14);
      tbl[n-1].addr  = 3'(n / 2);
      tbl[n-1].data  = 8'(17 * (n / 2));
      tbl[n-1].rd    = (n >= 13) ? 3'd7 : 3'((n + 1) / 2);
      tbl[n-1].busy  = (n <= 15);
      tbl[n-1].done  = (n == 15);
    end

    rst = 1'b1; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; if_a.ready = 0; if_b.ready = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_valid", if_b.valid, 0);
    rst = 1'b0;
    load_default();

    start_a_pulse();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d_valid", i + 1), if_a.valid, tbl[i].valid);
      chk($sformatf("tbl%0d_busy", i + 1), busy_a, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i + 1), done_a, tbl[i].done);
      chk($sformatf("tbl%0d_rdaddr", i + 1), rd_addr_a, tbl[i].rd);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_addr", i + 1), if_a.addr, tbl[i].addr);
        chk($sformatf("tbl%0d_data", i + 1), if_a.data, tbl[i].data);
        chk($sformatf("tbl%0d_stale", i + 1), if_a.stale, 0);
      end
      start_a = tbl[i].start;
      if_a.ready = tbl[i].ready;
      tick();
    end
    start_a = 1'b0;

    // Backpressure on R3 for 5 cycles.
    base = hs_cnt_a;
    if_a.ready = 1'b1;
    start_a_pulse();
    wait_byte(3'd3);
    if_a.ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", if_a.valid, 1);
      chk("bp_addr", if_a.addr, 3);
      chk("bp_data", if_a.data, 8'h33);
    end
    if_a.ready = 1'b1;
    tick();
    chk("bp_gap_valid", if_a.valid, 0);
    tick();
    chk("bp_next_addr", if_a.addr, 4);
    chk("bp_next_data", if_a.data, 8'h44);
    wait_done();
    chk("bp_count", hs_cnt_a - base, 7);

    // Stale: unrelated write, then overwrite of the held register.
    start_a_pulse();
    wait_byte(3'd2);
    if_a.ready = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h55;
    tick();
    chk("stale_other", if_a.stale, 0);
    wr_addr = 3'd2; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    chk("stale_set", if_a.stale, 1);
    chk("stale_data", if_a.data, 8'h22);
    chk("stale_valid", if_a.valid, 1);
    if_a.ready = 1'b1;
    wait_done();
    write_reg(3'd2, 8'h22);

    // Write during the READ of R4 captures the old value, flagged stale.
    start_a_pulse();
    wait_byte(3'd3);
    tick();
    chk("cap_rdaddr", rd_addr_a, 4);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("cap_valid", if_a.valid, 1);
    chk("cap_addr", if_a.addr, 4);
    chk("cap_data", if_a.data, 8'h44);
    chk("cap_stale", if_a.stale, 1);
    wait_done();
    write_reg(3'd4, 8'h44);

    // Abort while R5 is offered (and accepted in the same cycle).
    base = hs_cnt_a;
    start_a_pulse();
    wait_byte(3'd5);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_valid", if_a.valid, 0);
    chk("abort_busy", busy_a, 0);
    repeat (4) begin
      tick();
      chk("abort_no_done", done_a, 0);
      chk("abort_idle", busy_a, 0);
    end
    chk("abort_count", hs_cnt_a - base, 5);

    // Reset mid-dump.
    start_a_pulse();
    wait_byte(3'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    load_default();

    // FIRST_REG=0, LAST_REG=2, GAP_CYCLES=3: byte k at cycle 2+5k, done at 13.
    if_b.ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      automatic bit ev = (n >= 2) && ((n - 2) % 5 == 0) && (n <= 12);
      automatic int k  = (n - 2) / 5;
      automatic int rk = ((n - 1) / 5 > 2) ? 2 : (n - 1) / 5;
      chk($sformatf("b%0d_valid", n), if_b.valid, int'(ev));
      chk($sformatf("b%0d_done", n), done_b, int'(n == 13));
      chk($sformatf("b%0d_busy", n), busy_b, int'(n <= 13));
      chk($sformatf("b%0d_rdaddr", n), rd_addr_b, rk);
      if (ev) begin
        chk($sformatf("b%0d_addr", n), if_b.addr, k);
        chk($sformatf("b%0d_data", n), if_b.data, 17 * k);
      end
      tick();
    end

    // Randomized dumps against a transaction-level model of dut_a.
    for (int d = 0; d < 20; d++) begin
      logic [7:0] snap [8];
      bit         prev_v, prev_r, prev_we, in_byte, hs, cur_s;
      logic [2:0] prev_a, prev_wa, cur_a;
      logic [7:0] cur_d;
      int         exp_idx, accepted, last_ev, cyc;
      for (int r = 1; r < 8; r++) write_reg(3'(r), 8'($urandom));
      prev_v = 0; prev_r = 0; prev_we = 0; prev_a = 0; prev_wa = 0;
      in_byte = 0; cur_s = 0; cur_a = 0; cur_d = 0;
      exp_idx = 1; accepted = 0; last_ev = 0; cyc = 1;
      if_a.ready = 1'b0;
      start_a_pulse();
      while (cyc < 300) begin
        hs = prev_v && prev_r;
        if (hs) begin
          accepted++;
          in_byte = 0;
          last_ev = cyc - 1;
        end
        chk("rnd_done", done_a, int'(hs && prev_a == 3'd7));
        if (if_a.valid) begin
          if (!in_byte) begin
            chk("rnd_rise_time", cyc, last_ev + 2);
            chk("rnd_addr", if_a.addr, exp_idx);
            chk("rnd_data", if_a.data, snap[exp_idx]);
            cur_s = prev_we && prev_wa == 3'(exp_idx) && exp_idx != 0;
            cur_a = 3'(exp_idx);
            cur_d = snap[exp_idx];
            in_byte = 1;
            exp_idx++;
          end else begin
            if (prev_we && prev_wa == cur_a && cur_a != 3'd0) cur_s = 1;
            chk("rnd_hold_addr", if_a.addr, cur_a);
            chk("rnd_hold_data", if_a.data, cur_d);
          end
          chk("rnd_stale", if_a.stale, cur_s);
        end else begin
          chk("rnd_valid_drop", in_byte, 0);
        end
        if (done_a) break;
        if_a.ready = ($urandom_range(0, 3) != 0);
        wr_en      = ($urandom_range(0, 3) == 0);
        wr_addr    = 3'($urandom_range(0, 7));
        wr_data    = 8'($urandom);
        prev_v = if_a.valid; prev_r = if_a.ready; prev_a = if_a.addr;
        prev_we = wr_en; prev_wa = wr_addr;
        snap = rf;
        tick();
        cyc++;
      end
      wr_en = 1'b0;
      chk("rnd_finished", int'(cyc < 300), 1);
      chk("rnd_count", accepted, 7);
      tick();
      chk("rnd_idle", busy_a, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_dump_engine.md
Name: regfile_dump_engine

Overview:
- Sequential reader for the 8 x 8-bit general-purpose register file.
- On `start`, walks registers FIRST_REG..LAST_REG through one register-file read port, then streams each {address, data} pair out over a valid/ready handshake to the debug/display path (LED mux, future UART TX).
- Snoops the register-file write port and flags any byte that went stale while held.

Parameters:
- FIRST_REG, 1: first register index dumped (0..7). Index 0 reads 0.
- LAST_REG, 7: last register index dumped (0..7). Must satisfy LAST_REG >= FIRST_REG; an elaboration-time assertion fails otherwise.
- GAP_CYCLES, 0: idle cycles inserted after each accepted byte, 0..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  cancel a dump in progress
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last byte is accepted
- rf_rd_addr  out  3  drives a register-file read-address port
- rf_rd_data  in  8  combinational read data from that port
- rf_wr_en  in  1  snooped register-file write enable
- rf_wr_addr  in  3  snooped register-file write address
- out_valid  out  1  out_addr, out_data and out_stale are valid
- out_ready  in  1  consumer accepts the byte
- out_addr  out  3  register index of the current byte
- out_data  out  8  captured register value
- out_stale  out  1  held register was written after capture

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state goes to IDLE.
  - busy, done, out_valid, out_stale = 0; out_addr, out_data, rf_rd_addr = 0.
  - Gap counter = 0.
  - rst overrides start and abort, and takes effect mid-dump with no done pulse.
- States: IDLE, READ, SEND, GAP, DONE.
- IDLE:
  - start=1 -> READ; internal index loads FIRST_REG.
  - start while busy is ignored (no restart, no queueing).
- READ (exactly 1 cycle):
  - rf_rd_addr = index.
  - At the edge: out_data <= rf_rd_data, out_addr <= index, out_stale <= 0, -> SEND.
  - If the same cycle has rf_wr_en=1 and rf_wr_addr==index, the old value is captured, so out_stale <= 1.
- rf_rd_addr holds its last driven value in all states other than READ.
- SEND:
  - out_valid=1.
  - out_addr, out_data and out_valid are stable until the handshake; out_stale may rise but never falls while valid.
  - Handshake = out_valid && out_ready at an edge.
  - On handshake with index==LAST_REG -> DONE.
  - On handshake otherwise: index+1, then GAP if GAP_CYCLES>0, else READ.
  - out_valid deasserts on the cycle after the handshake.
- Stale detect:
  - In SEND, rf_wr_en=1 with rf_wr_addr==out_addr and out_addr!=0 sets out_stale=1 at the next edge.
  - Writes to other addresses have no effect.
  - Writes to address 0 never set stale.
- GAP: counts GAP_CYCLES cycles, then -> READ.
- DONE: done=1 for exactly one cycle, busy=1, -> IDLE.
- abort:
  - In READ/SEND/GAP: next state IDLE, out_valid=0, no done pulse.
  - A handshake in the same cycle as abort is still counted as accepted by the consumer, but no further bytes follow.
  - abort in IDLE or DONE has no effect; DONE still completes.
- Latency with GAP_CYCLES=0 and out_ready tied high:
  - start sampled at edge 0.
  - Byte k valid in cycle 2(k-FIRST_REG+1).
  - done in the cycle after the last handshake. Defaults: bytes in cycles 2,4,...,14; done in cycle 15.
- Index wrap: never needed, because the dump ends at LAST_REG; the 3-bit index must not increment past 7.

Test Plan:
- Basic dump: R1..R7 = 11,22,...,77; pulse start; out_ready=1 -> seven bytes (1,11)..(7,77) in cycles 2,4,...,14; done=1 in cycle 15 only; out_stale=0 throughout.
- Backpressure: out_ready=0 for 5 cycles on byte R3=33 -> out_valid held, out_addr=3 and out_data=33 stable; on release the next byte is (4,44); total bytes = 7.
- Stale: while SEND holds (2,22), write R2<=99 -> out_stale=1 from the next cycle, out_data stays 22. A write to R5 at the same point leaves out_stale=0.
- Same-cycle capture: write R4<=A5 during READ of index 4 -> out_data=old 44, out_stale=1.
- Abort/reset mid-dump: abort during SEND of R5 -> out_valid=0, busy=0 next cycle, no done. Repeat with rst -> all outputs 0 next cycle. A start during busy is ignored.
- Params FIRST_REG=0, LAST_REG=2, GAP_CYCLES=3 -> bytes (0,00),(1,..),(2,..); 3 idle cycles between handshake and the next READ; done after byte 2.
